// File: rtl/regfile_seq_pkg.sv
// Shared types and default geometry for the register-file address sequencer.
package regfile_seq_pkg;

  localparam int unsigned AW_DEF   = 6;
  localparam int unsigned LEAD_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_seq_ctrl.sv
// Read/write address sequencer for the regfile -> ALU -> write-back loop:
// primes the read port, then sweeps reads while writing LEAD registers ahead.
module regfile_seq_ctrl
  import regfile_seq_pkg::*;
#(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned LEAD = LEAD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          stall,
  output logic [AW-1:0] r_addr,
  output logic [AW-1:0] w_addr,
  output logic          w_ena,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] waddr_q;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          w_ena_c;

  // State register plus registered address/status decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      waddr_q <= AW'(LEAD);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      waddr_q <= ptr_d + AW'(LEAD);
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, pointer/count stepping, and the write strobe.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    w_ena_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = base;
          cnt_d   = len;
          state_d = (len != '0) ? ST_PRIME : ST_DONE;
        end
      end
      ST_PRIME: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        w_ena_c = ~stall;
        // A stalled cycle leaves pointer and count untouched so it repeats.
        if (!stall) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_PRIME) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign r_addr = ptr_q;
  assign w_addr = waddr_q;
  assign w_ena  = w_ena_c;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed plus randomized bench for regfile_seq_ctrl against a phase-level reference model.
module tb_regfile_seq_ctrl;
  import regfile_seq_pkg::*;

  localparam int unsigned AW   = 6;
  localparam int unsigned LEAD = 2;
  localparam int          NREG = 64;

  localparam int PH_IDLE  = 0;
  localparam int PH_PRIME = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_DONE  = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          stall;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr;
  logic          w_ena;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  // Reference model: sweep phase, next read register, writes still owed.
  int m_phase;
  int m_ptr;
  int m_left;
  int m_len;
  int obs_writes;

  regfile_seq_ctrl #(.AW(AW), .LEAD(LEAD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .len    (len),
    .stall  (stall),
    .r_addr (r_addr),
    .w_addr (w_addr),
    .w_ena  (w_ena),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_phase    = PH_IDLE;
    m_ptr      = 0;
    m_left     = 0;
    m_len      = 0;
    obs_writes = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".r_addr"}, 32'(r_addr), 0);
    chk({tag, ".w_addr"}, 32'(w_addr), int'(LEAD));
    chk({tag, ".w_ena"},  32'(w_ena),  0);
    chk({tag, ".busy"},   32'(busy),   0);
    chk({tag, ".done"},   32'(done),   0);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model at the edge.
  task automatic step(input logic s, input int b, input int l, input logic st);
    @(negedge clk);
    start = s;
    base  = AW'(b);
    len   = AW'(l);
    stall = st;
    #1;
    chk("r_addr", 32'(r_addr), m_ptr);
    chk("w_addr", 32'(w_addr), (m_ptr + int'(LEAD)) % NREG);
    chk("w_ena",  32'(w_ena),  (m_phase == PH_RUN && !st) ? 1 : 0);
    chk("busy",   32'(busy),   (m_phase == PH_PRIME || m_phase == PH_RUN) ? 1 : 0);
    chk("done",   32'(done),   (m_phase == PH_DONE) ? 1 : 0);
    if (w_ena === 1'b1) obs_writes++;
    if (m_phase == PH_DONE) chk("write_count", 32'(obs_writes), m_len);
    @(posedge clk);
    case (m_phase)
      PH_IDLE: if (s) begin
        m_ptr      = b % NREG;
        m_left     = l % NREG;
        m_len      = m_left;
        obs_writes = 0;
        m_phase    = (m_left != 0) ? PH_PRIME : PH_DONE;
      end
      PH_PRIME: m_phase = PH_RUN;
      PH_RUN: if (!st) begin
        m_ptr  = (m_ptr + 1) % NREG;
        m_left = m_left - 1;
        if (m_left == 0) m_phase = PH_DONE;
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    start = 1'b0;
    base  = '0;
    len   = '0;
    stall = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Power-on reset.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // Basic sweep base=0 len=4.
    step(1'b1, 0, 4, 1'b0);
    idle(7);

    // Wrap across the top of the register file.
    step(1'b1, 62, 4, 1'b0);
    idle(7);

    // Stall on the second RUN cycle.
    step(1'b1, 5, 3, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    idle(5);

    // len=0 goes straight to DONE.
    step(1'b1, 17, 0, 1'b0);
    idle(3);

    // start pulsed during RUN and in DONE is ignored.
    step(1'b1, 30, 3, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 10, 7, 1'b0);
    step(1'b1, 11, 2, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 40, 5, 1'b0);
    idle(2);

    // Reset mid-sweep, then a fresh sweep from a new base.
    step(1'b1, 20, 10, 1'b0);
    idle(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 50, 3, 1'b0);
    idle(6);

    // Randomized traffic, including stalls in PRIME and zero-length sweeps.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, NREG - 1)),
           int'($urandom_range(0, 9)),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    idle(15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
